ssd_digit_scanner: RTL
======================

// Module: ssd_digit_scanner
// PURPOSE
//  Time-multiplexed scanner for an N-digit common-anode seven-segment display.
//  Holds an N-digit hex value and presents one digit nibble per time slot on
//  digit_nibble, which drives the registered hex-to-segment decoder's 4-bit
//  digit input. It also drives the matching active-low anode enables.
//  New values are double-buffered and committed only at frame boundaries
//  (no tearing). A blanking window hides the decoder's 1-cycle latency (no ghosting).
// PARAMETERS
//  N_DIGITS      4       number of digits scanned (>=2)
//  REFRESH_DIV   100000  clk cycles per digit slot (>=4)
//  BLANK_CYCLES  1000    cycles at start of each slot with all anodes off (1..REFRESH_DIV-2)
// PORTS
//  clk           in   1           system clock, all logic on rising edge
//  rst_n         in   1           asynchronous reset, active-low
//  value_in      in   4*N_DIGITS  hex value; digit k = value_in[4k+3:4k], digit 0 = rightmost
//  load          in   1           1-cycle strobe: capture value_in into shadow register
//  pending       out  1           shadow holds a value not yet committed to display
//  digit_nibble  out  4           nibble of current digit, to decoder digit input
//  digit_an_n    out  N_DIGITS    anode enables, active-low, at most one bit low
//  frame_start   out  1           1-cycle pulse when slot of digit 0 begins
// BEHAVIOUR
//  Reset (async on rst_n=0, held until release): slot counter cnt=0, idx=0, disp=0,
//   shadow=0, pending=0, digit_nibble=0, digit_an_n=all 1s, frame_start=0.
//  All outputs are registered. There are no combinational paths from inputs to outputs.
//  Slot timing: cnt counts 0..REFRESH_DIV-1 every cycle.
//   At cnt==REFRESH_DIV-1, cnt wraps to 0.
//   On that same wrap, idx <= (idx==N_DIGITS-1) ? 0 : idx+1.
//  State per slot, decoded from cnt:
//   BLANK (cnt < BLANK_CYCLES): digit_an_n = all 1s.
//   SHOW (cnt >= BLANK_CYCLES): digit_an_n = ~(1<<idx).
//  digit_nibble = disp[4*idx +: 4], updated on the edge idx changes.
//   It is therefore stable for the whole BLANK window before the anode turns on.
//  Frame: the wrap into idx=0 is a frame boundary. On that edge frame_start<=1.
//   frame_start returns to 0 on the next edge.
//   frame_start is NOT asserted for the first slot after reset.
//  Load/commit:
//   load=1 -> shadow<=value_in, pending<=1 (any cycle, any state).
//   Frame boundary with pending=1 -> disp<=shadow, pending<=0.
//    digit_nibble on that same edge shows the NEW digit 0.
//   Frame boundary with pending=0 -> disp unchanged.
//   load coincident with frame boundary -> disp<=value_in directly (bypass),
//    shadow<=value_in, pending<=0.
//   Multiple loads within one frame: last one wins; only it is committed.
//  Commit latency: from load to the new digit 0 visible on digit_nibble is at most
//   N_DIGITS*REFRESH_DIV cycles. On the anodes, add BLANK_CYCLES.
//  Reset mid-frame: immediate return to reset values.
//   The pending value is discarded; disp=0.
//  Invariant: digit_an_n is never low for two digits at once.
//   It is never low during BLANK.
// TESTING (N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2 unless stated)
//  1 Reset: assert rst_n=0 mid-SHOW with disp=16'h1234
//    -> same cycle digit_an_n=4'b1111, digit_nibble=0, pending=0.
//  2 Scan: load 16'hA5C3 then run 2 frames
//    -> nibble sequence 3,C,5,A, each for 8 cycles.
//    -> each slot: anodes 1111 for 2 cycles, then the single low bit for 6.
//    -> frame_start pulses every 32 cycles.
//  3 Double-buffer: disp=16'h0000, load 16'hFFFF mid-slot of idx=2
//    -> digits 2,3 still show 0, pending=1.
//    -> at the next frame_start the nibble becomes F and pending=0.
//  4 Last-wins: load 16'h1111 then 16'h2222 in the same frame
//    -> the next frame shows only 2s; 1s never appear.
//  5 Coincident: load 16'hBEEF on the exact boundary cycle
//    -> that edge digit_nibble=F, pending=0.
//  6 Assertion over 10k random cycles with random loads:
//    -> popcount(~digit_an_n)<=1.
//    -> no anode low while cnt<BLANK_CYCLES.

Source files
------------

// File: rtl/ssd_digit_scanner.sv
// ssd_digit_scanner: time-multiplexed N-digit seven-segment scanner with
// frame-synchronous double-buffered value and per-slot anode blanking.
module ssd_digit_scanner #(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*N_DIGITS-1:0] value_in,
    input  logic                  load,
    output logic                  pending,
    output logic [3:0]            digit_nibble,
    output logic [N_DIGITS-1:0]   digit_an_n,
    output logic                  frame_start
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(N_DIGITS);
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*N_DIGITS-1:0]   disp_q, disp_d, shadow_q, shadow_d;
    logic                    pending_q, pending_d, frame_start_q, frame_start_d;
    logic [3:0]              digit_nibble_q, digit_nibble_d;
    logic [N_DIGITS-1:0]     digit_an_n_q, digit_an_n_d;
    logic                    wrap, boundary;
    always_comb begin
        wrap           = cnt_q == CW'(REFRESH_DIV - 1);
        boundary       = wrap && idx_q == IW'(N_DIGITS - 1);
        cnt_d          = wrap ? '0 : cnt_q + CW'(1);
        idx_d          = boundary ? '0 : wrap ? idx_q + IW'(1) : idx_q;
        shadow_d       = load ? value_in : shadow_q;
        pending_d      = boundary ? 1'b0 : (load | pending_q);
        // A load landing on the boundary edge bypasses the shadow straight to the display
        disp_d         = !boundary ? disp_q : load ? value_in : pending_q ? shadow_q : disp_q;
        frame_start_d  = boundary;
        digit_nibble_d = disp_d[{idx_d, 2'b00} +: 4];
        // Anodes are decoded from next-state so the registered output tracks cnt_q exactly
        digit_an_n_d   = (cnt_d < CW'(BLANK_CYCLES)) ? '1 : ~(N_DIGITS'(1) << idx_d);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q          <= '0;
            idx_q          <= '0;
            disp_q         <= '0;
            shadow_q       <= '0;
            pending_q      <= 1'b0;
            frame_start_q  <= 1'b0;
            digit_nibble_q <= '0;
            digit_an_n_q   <= '1;
        end else begin
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            disp_q         <= disp_d;
            shadow_q       <= shadow_d;
            pending_q      <= pending_d;
            frame_start_q  <= frame_start_d;
            digit_nibble_q <= digit_nibble_d;
            digit_an_n_q   <= digit_an_n_d;
        end
    end
    assign pending      = pending_q;
    assign digit_nibble = digit_nibble_q;
    assign digit_an_n   = digit_an_n_q;
    assign frame_start  = frame_start_q;
endmodule
